cal_exe: RTL and testbench

Execution stage of the calculator, directly downstream of the input FSM in the top level. On a start pulse it captures the two signed 3-digit BCD operands and an opcode. It converts both operands to binary and runs a single-cycle or multi-cycle arithmetic operation. It then converts the result back to 6 BCD digits plus sign for the display stage, and signals completion with a one-cycle done pulse.

---
 rtl/cal_exe.sv | 175 +++++++++++++++++
 tb/tb_cal_exe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cal_exe.sv
// Calculator execution stage: captures two signed 3-digit BCD operands, runs add/sub/mul/div
// on binary magnitudes, and converts the result back to 6 BCD digits plus sign.
module cal_exe #(
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   exe_start,
    input  logic [2:0]             exe_op,
    input  logic [DIGIT_WIDTH-1:0] a_digit0,
    input  logic [DIGIT_WIDTH-1:0] a_digit1,
    input  logic [DIGIT_WIDTH-1:0] a_digit2,
    input  logic                   a_sign,
    input  logic [DIGIT_WIDTH-1:0] b_digit0,
    input  logic [DIGIT_WIDTH-1:0] b_digit1,
    input  logic [DIGIT_WIDTH-1:0] b_digit2,
    input  logic                   b_sign,
    output logic                   exe_busy,
    output logic                   exe_done,
    output logic [DIGIT_WIDTH-1:0] res_digit0,
    output logic [DIGIT_WIDTH-1:0] res_digit1,
    output logic [DIGIT_WIDTH-1:0] res_digit2,
    output logic [DIGIT_WIDTH-1:0] res_digit3,
    output logic [DIGIT_WIDTH-1:0] res_digit4,
    output logic [DIGIT_WIDTH-1:0] res_digit5,
    output logic                   res_sign,
    output logic                   res_err
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CONV = 3'd1;
    localparam logic [2:0] ST_CALC = 3'd2;
    localparam logic [2:0] ST_BCD  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]             state_q, state_d, op_q;
    logic [DIGIT_WIDTH-1:0] a_d0_q, a_d1_q, a_d2_q, b_d0_q, b_d1_q, b_d2_q;
    logic                   a_sign_q, b_sign_q, neg_q, err_q, busy_q, done_q, res_sign_q, res_err_q;
    logic [4:0]             cnt_q;
    logic [9:0]             mag_a_q, mag_b_q, mplier_q, quo_q, rem_q;
    logic [19:0]            mcand_q, prod_q, bin_q;
    logic [23:0]            bcd_q, res_bcd_q;

    logic [9:0]         mag_a_s, mag_b_s, rem_next_s, quo_next_s;
    logic               err_s, fits_s;
    logic signed [11:0] sa_s, sb_s, sum_s;
    logic [11:0]        sum_abs_s;
    logic [19:0]        prod_next_s, mag_res_s;
    logic [10:0]        trial_s;
    logic [43:0]        dabble_s;

    function automatic logic [9:0] to_bin(input logic [DIGIT_WIDTH-1:0] d2,
                                          input logic [DIGIT_WIDTH-1:0] d1,
                                          input logic [DIGIT_WIDTH-1:0] d0);
        return 10'(16'(d2) * 16'd100 + 16'(d1) * 16'd10 + 16'(d0));
    endfunction

    function automatic logic digit_bad(input logic [DIGIT_WIDTH-1:0] d);
        return d > DIGIT_WIDTH'(9);
    endfunction

    function automatic logic [23:0] add3_fix(input logic [23:0] v);
        logic [23:0] r;
        r = v;
        for (int i = 0; i < 6; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Operand conversion, validity check and per-cycle arithmetic step values
    always_comb begin
        mag_a_s = to_bin(a_d2_q, a_d1_q, a_d0_q);
        mag_b_s = to_bin(b_d2_q, b_d1_q, b_d0_q);
        err_s   = digit_bad(a_d0_q) | digit_bad(a_d1_q) | digit_bad(a_d2_q) |
                  digit_bad(b_d0_q) | digit_bad(b_d1_q) | digit_bad(b_d2_q) |
                  op_q[2] | ((op_q == 3'b011) && (mag_b_s == 10'd0));
        sa_s      = a_sign_q ? -$signed({2'b00, mag_a_q}) : $signed({2'b00, mag_a_q});
        sb_s      = b_sign_q ? -$signed({2'b00, mag_b_q}) : $signed({2'b00, mag_b_q});
        sum_s     = op_q[0] ? (sa_s - sb_s) : (sa_s + sb_s);
        sum_abs_s = sum_s[11] ? $unsigned(-sum_s) : $unsigned(sum_s);
        prod_next_s = prod_q + (mplier_q[0] ? mcand_q : 20'd0);
        // Restoring division: bring in the next dividend bit, subtract if the divisor fits
        trial_s    = {rem_q, quo_q[9]};
        fits_s     = trial_s >= {1'b0, mag_b_q};
        rem_next_s = fits_s ? 10'(trial_s - {1'b0, mag_b_q}) : trial_s[9:0];
        quo_next_s = {quo_q[8:0], fits_s};
        mag_res_s  = op_q[0] ? {10'd0, quo_next_s} : prod_next_s;
        dabble_s   = {add3_fix(bcd_q), bin_q} << 1;
    end

    // Next-state logic of the sequencing FSM
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: if (exe_start) state_d = ST_CONV; else state_d = ST_IDLE;
            ST_CONV: if (err_s) state_d = ST_DONE; else state_d = ST_CALC;
            ST_CALC: if (!op_q[1] || (cnt_q == 5'd9)) state_d = ST_BCD; else state_d = ST_CALC;
            ST_BCD:  if (cnt_q == 5'd19) state_d = ST_DONE; else state_d = ST_BCD;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;  op_q <= 3'd0;  cnt_q <= 5'd0;
            a_d0_q <= '0; a_d1_q <= '0; a_d2_q <= '0; b_d0_q <= '0; b_d1_q <= '0; b_d2_q <= '0;
            a_sign_q <= 1'b0; b_sign_q <= 1'b0; neg_q <= 1'b0; err_q <= 1'b0;
            mag_a_q <= 10'd0; mag_b_q <= 10'd0; mplier_q <= 10'd0; quo_q <= 10'd0; rem_q <= 10'd0;
            mcand_q <= 20'd0; prod_q <= 20'd0; bin_q <= 20'd0; bcd_q <= 24'd0;
            busy_q <= 1'b0; done_q <= 1'b0;
            res_bcd_q <= 24'd0; res_sign_q <= 1'b0; res_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_q != ST_IDLE;
            done_q  <= state_q == ST_DONE;
            case (state_q)
                ST_IDLE: if (exe_start) begin
                    op_q <= exe_op; a_sign_q <= a_sign; b_sign_q <= b_sign;
                    a_d0_q <= a_digit0; a_d1_q <= a_digit1; a_d2_q <= a_digit2;
                    b_d0_q <= b_digit0; b_d1_q <= b_digit1; b_d2_q <= b_digit2;
                end
                ST_CONV: begin
                    mag_a_q <= mag_a_s;  mag_b_q <= mag_b_s;
                    mcand_q <= {10'd0, mag_a_s};  mplier_q <= mag_b_s;  prod_q <= 20'd0;
                    quo_q <= mag_a_s;  rem_q <= 10'd0;
                    cnt_q <= 5'd0;  bin_q <= 20'd0;  bcd_q <= 24'd0;
                    neg_q <= 1'b0;  err_q <= err_s;
                end
                ST_CALC: begin
                    if (!op_q[1]) begin
                        bin_q <= {8'd0, sum_abs_s};
                        neg_q <= sum_s[11];
                    end else begin
                        prod_q <= prod_next_s;  mcand_q <= mcand_q << 1;  mplier_q <= mplier_q >> 1;
                        rem_q <= rem_next_s;  quo_q <= quo_next_s;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd9) begin
                            bin_q <= mag_res_s;
                            neg_q <= (a_sign_q ^ b_sign_q) && (mag_res_s != 20'd0);
                            cnt_q <= 5'd0;
                        end
                    end
                end
                ST_BCD: begin
                    bcd_q <= dabble_s[43:20];
                    bin_q <= dabble_s[19:0];
                    cnt_q <= cnt_q + 5'd1;
                end
                ST_DONE: begin
                    res_bcd_q  <= bcd_q;
                    res_sign_q <= neg_q;
                    res_err_q  <= err_q;
                end
                default: cnt_q <= 5'd0;
            endcase
        end
    end

    assign exe_busy   = busy_q;
    assign exe_done   = done_q;
    assign res_digit0 = DIGIT_WIDTH'(res_bcd_q[3:0]);
    assign res_digit1 = DIGIT_WIDTH'(res_bcd_q[7:4]);
    assign res_digit2 = DIGIT_WIDTH'(res_bcd_q[11:8]);
    assign res_digit3 = DIGIT_WIDTH'(res_bcd_q[15:12]);
    assign res_digit4 = DIGIT_WIDTH'(res_bcd_q[19:16]);
    assign res_digit5 = DIGIT_WIDTH'(res_bcd_q[23:20]);
    assign res_sign   = res_sign_q;
    assign res_err    = res_err_q;
endmodule

// File: tb/tb_cal_exe.sv
// Self-checking bench for cal_exe: directed cases plus random operations against an
// integer-arithmetic reference model with cycle-exact latency expectations.
module tb_cal_exe;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       exe_start = 1'b0;
    logic [2:0] exe_op = 3'd0;
    logic [3:0] a_digit0 = 4'd0, a_digit1 = 4'd0, a_digit2 = 4'd0;
    logic [3:0] b_digit0 = 4'd0, b_digit1 = 4'd0, b_digit2 = 4'd0;
    logic       a_sign = 1'b0, b_sign = 1'b0;
    logic       exe_busy, exe_done, res_sign, res_err;
    logic [3:0] res_digit0, res_digit1, res_digit2, res_digit3, res_digit4, res_digit5;
    logic [3:0] res_d [6];

    int n_cmp = 0;
    int n_bad = 0;

    cal_exe #(.DIGIT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .exe_start(exe_start), .exe_op(exe_op),
        .a_digit0(a_digit0), .a_digit1(a_digit1), .a_digit2(a_digit2), .a_sign(a_sign),
        .b_digit0(b_digit0), .b_digit1(b_digit1), .b_digit2(b_digit2), .b_sign(b_sign),
        .exe_busy(exe_busy), .exe_done(exe_done),
        .res_digit0(res_digit0), .res_digit1(res_digit1), .res_digit2(res_digit2),
        .res_digit3(res_digit3), .res_digit4(res_digit4), .res_digit5(res_digit5),
        .res_sign(res_sign), .res_err(res_err)
    );

    assign res_d[0] = res_digit0;
    assign res_d[1] = res_digit1;
    assign res_d[2] = res_digit2;
    assign res_d[3] = res_digit3;
    assign res_d[4] = res_digit4;
    assign res_d[5] = res_digit5;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_inputs(input int a2, input int a1, input int a0, input bit as_,
                              input int b2, input int b1, input int b0, input bit bs_, input int op);
        a_digit2 = 4'(a2); a_digit1 = 4'(a1); a_digit0 = 4'(a0); a_sign = as_;
        b_digit2 = 4'(b2); b_digit1 = 4'(b1); b_digit0 = 4'(b0); b_sign = bs_;
        exe_op = 3'(op);
    endtask

    task automatic scramble();
        set_inputs($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
                   $urandom_range(0, 7));
    endtask

    // One operation; `again` is the cycle at which a stray start is issued (-1 for none)
    task automatic run_op(input int a2, input int a1, input int a0, input bit as_,
                          input int b2, input int b1, input int b0, input bit bs_,
                          input int op, input int again);
        int ma, mb, sa, sb, r, emag, n, p;
        bit eerr;
        ma = a2 * 100 + a1 * 10 + a0;
        mb = b2 * 100 + b1 * 10 + b0;
        eerr = (a2 > 9) || (a1 > 9) || (a0 > 9) || (b2 > 9) || (b1 > 9) || (b0 > 9) ||
               (op > 3) || (op == 3 && mb == 0);
        sa = as_ ? -ma : ma;
        sb = bs_ ? -mb : mb;
        r = 0;
        if (!eerr) begin
            case (op)
                0: r = sa + sb;
                1: r = sa - sb;
                2: r = sa * sb;
                default: r = sa / sb;
            endcase
        end
        emag = (r < 0) ? -r : r;
        n = eerr ? 2 : ((op < 2) ? 23 : 32);

        @(negedge clk);
        set_inputs(a2, a1, a0, as_, b2, b1, b0, bs_, op);
        exe_start = 1'b1;
        @(posedge clk);
        #1;
        exe_start = 1'b0;
        scramble();
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            exe_start = (k == again);
            if (k == again) scramble();
            @(posedge clk);
            #1;
            check($sformatf("busy_c%0d", k), 32'(exe_busy), 32'(k <= n));
            check($sformatf("done_c%0d", k), 32'(exe_done), 32'(k == n));
            if (k >= n) begin
                p = 1;
                for (int i = 0; i < 6; i++) begin
                    check($sformatf("digit%0d_c%0d", i, k), 32'(res_d[i]), 32'((emag / p) % 10));
                    p = p * 10;
                end
                check($sformatf("sign_c%0d", k), 32'(res_sign), 32'(r < 0));
                check($sformatf("err_c%0d", k), 32'(res_err), 32'(eerr));
            end
        end
        exe_start = 1'b0;
    endtask

    initial begin
        int seen;
        int op, bz;
        int d [6];

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(exe_busy), 32'd0);
        check("rst_done", 32'(exe_done), 32'd0);
        check("rst_digits", {8'd0, res_digit5, res_digit4, res_digit3, res_digit2, res_digit1, res_digit0}, 32'd0);
        check("rst_sign", 32'(res_sign), 32'd0);
        check("rst_err", 32'(res_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(1, 2, 3, 1'b0, 4, 5, 6, 1'b1, 0, -1);
        run_op(9, 9, 9, 1'b0, 9, 9, 9, 1'b0, 2, -1);
        run_op(0, 0, 7, 1'b1, 0, 0, 2, 1'b0, 3, -1);
        run_op(0, 0, 5, 1'b1, 0, 0, 0, 1'b0, 2, -1);
        run_op(0, 0, 5, 1'b0, 0, 0, 0, 1'b1, 3, -1);
        run_op(0, 0, 5, 1'b0, 0, 0, 0, 1'b1, 5, -1);
        run_op(0, 10, 5, 1'b0, 0, 0, 0, 1'b1, 0, -1);
        run_op(9, 9, 9, 1'b0, 9, 9, 9, 1'b0, 2, 5);

        // Reset in cycle 10 of a division aborts it silently
        @(negedge clk);
        set_inputs(1, 2, 3, 1'b0, 0, 0, 4, 1'b0, 3);
        exe_start = 1'b1;
        @(posedge clk);
        #1;
        exe_start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(exe_busy), 32'd0);
        check("abort_done", 32'(exe_done), 32'd0);
        check("abort_digits", {8'd0, res_digit5, res_digit4, res_digit3, res_digit2, res_digit1, res_digit0}, 32'd0);
        check("abort_sign_err", {30'd0, res_sign, res_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (exe_done || exe_busy) seen = 1;
        end
        check("abort_quiet", 32'(seen), 32'd0);
        run_op(0, 5, 0, 1'b0, 0, 7, 5, 1'b0, 1, -1);

        // Start coincident with reset is not captured
        @(negedge clk);
        set_inputs(0, 0, 1, 1'b0, 0, 0, 1, 1'b0, 0);
        exe_start = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exe_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (exe_done || exe_busy) seen = 1;
        end
        check("rst_start_ignored", 32'(seen), 32'd0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 6; i++) begin
                d[i] = ($urandom_range(0, 24) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            end
            op = $urandom_range(0, 9);
            op = (op >= 8) ? $urandom_range(4, 7) : (op % 4);
            bz = (op == 3 || op == 2) && ($urandom_range(0, 5) == 0);
            if (bz != 0) begin
                d[3] = 0; d[4] = 0; d[5] = 0;
            end
            run_op(d[0], d[1], d[2], 1'($urandom), d[3], d[4], d[5], 1'($urandom), op,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
